// File: rtl/sad_pkg.sv
// Shared types and helpers for the SAD processing-element array.
// Module parameters override the default widths declared here.
package sad_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int NUM_PE_DEF = 16;
    localparam int BLK_DEF    = 16;

    typedef logic [PIX_W_DEF-1:0] pix_t;
    typedef logic [ACC_W_DEF-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Unsigned add clamped at 2^width-1; valid for width up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/sad_pe_array_if.sv
// Beat input stream and result drain stream of the SAD PE array.
interface sad_pe_array_if #(
    parameter int NUM_PE = 16,
    parameter int PIX_W  = 8,
    parameter int ACC_W  = 16,
    parameter int IDX_W  = $clog2(NUM_PE)
) ();

    // Both streams transfer on a cycle where valid && ready is high at the
    // rising clock edge; r_valid may toggle freely, out_valid holds its
    // payload stable until out_ready accepts it.
    logic               r_valid;
    logic               r_ready;
    logic [PIX_W-1:0]   r_pix;
    logic [PIX_W-1:0]   s1_pix;
    logic [PIX_W-1:0]   s2_pix;
    logic [NUM_PE-1:0]  s_sel;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_dist;
    logic [IDX_W-1:0]   out_idx;

    modport master (
        output r_valid, r_pix, s1_pix, s2_pix, s_sel, out_ready,
        input  r_ready, out_valid, out_dist, out_idx
    );

    modport slave (
        input  r_valid, r_pix, s1_pix, s2_pix, s_sel, out_ready,
        output r_ready, out_valid, out_dist, out_idx
    );

endinterface

// File: rtl/sad_pe.sv
// One systolic PE: R delay stage, search-bus select, |R-S| and a sticky
// saturating accumulator whose final value is parked until drained.
module sad_pe
    import sad_pkg::*;
#(
    parameter int K     = 0,
    parameter int PIX_W = 8,
    parameter int ACC_W = 16,
    parameter int BLK   = 16,
    parameter int CNT_W = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             beat_en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [PIX_W-1:0] r_in,
    output logic [PIX_W-1:0] r_out,
    input  logic [PIX_W-1:0] s1_pix,
    input  logic [PIX_W-1:0] s2_pix,
    input  logic             sel,
    input  logic             clr_pend,
    output logic             pend,
    output logic [ACC_W-1:0] result
);

    localparam int BEATS = BLK * BLK;

    logic [PIX_W-1:0]      r_q, r_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]      res_q, res_d;
    logic                  pend_q, pend_d;

    logic [PIX_W-1:0]      s_pix;
    logic signed [PIX_W:0] diff;
    logic [PIX_W-1:0]      d;
    logic [ACC_W-1:0]      sum;
    logic                  active;
    logic                  first;
    logic                  last;

    always_comb begin
        s_pix  = sel ? s1_pix : s2_pix;
        // One extra bit keeps the difference exact for any pixel pair.
        diff   = $signed({1'b0, r_in}) - $signed({1'b0, s_pix});
        d      = diff[PIX_W] ? PIX_W'(-diff) : PIX_W'(diff);
        active = (int'(cnt) >= K) && (int'(cnt) < K + BEATS);
        first  = (int'(cnt) == K);
        last   = (int'(cnt) == K + BEATS - 1);
        sum    = first ? ACC_W'(d)
                       : ACC_W'(sat_add(32'(acc_q), 32'(d), ACC_W));

        r_d    = r_q;
        acc_d  = acc_q;
        res_d  = res_q;
        pend_d = pend_q & ~clr_pend;
        if (beat_en) begin
            r_d = r_in;
            if (active) begin
                acc_d = sum;
                if (last) begin
                    res_d  = sum;
                    pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            pend_q <= pend_d;
        end
    end

    assign r_out  = r_q;
    assign pend   = pend_q;
    assign result = res_q;

endmodule

// File: rtl/sad_pe_array.sv
// NUM_PE systolic SAD engines sharing one R pipeline and two search buses,
// with a beat counter, pass FSM and a lowest-index-first result drain.
module sad_pe_array
    import sad_pkg::*;
#(
    parameter int NUM_PE = 16,
    parameter int PIX_W  = 8,
    parameter int ACC_W  = 16,
    parameter int BLK    = 16,
    parameter int IDX_W  = $clog2(NUM_PE)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    sad_pe_array_if.slave bus,
    output logic         busy,
    output logic         done,
    output state_e       dbg_state
);

    localparam int BEATS = BLK * BLK;
    localparam int LAST  = BEATS + NUM_PE - 2;
    localparam int CNT_W = $clog2(BEATS + NUM_PE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               beat_en;
    logic [PIX_W-1:0]   r_chain [NUM_PE+1];
    logic [NUM_PE-1:0]  pend;
    logic [NUM_PE-1:0]  clr_pend;
    logic [ACC_W-1:0]   result [NUM_PE];

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [ACC_W-1:0]   sel_dist;

    assign beat_en    = (state_q == RUN) && bus.r_valid;
    assign r_chain[0] = bus.r_pix;

    // PE k compares against R delayed by k accepted beats via the chain.
    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        sad_pe #(
            .K     (k),
            .PIX_W (PIX_W),
            .ACC_W (ACC_W),
            .BLK   (BLK),
            .CNT_W (CNT_W)
        ) u_pe (
            .clock    (clock),
            .reset    (reset),
            .beat_en  (beat_en),
            .cnt      (cnt_q),
            .r_in     (r_chain[k]),
            .r_out    (r_chain[k+1]),
            .s1_pix   (bus.s1_pix),
            .s2_pix   (bus.s2_pix),
            .sel      (bus.s_sel[k]),
            .clr_pend (clr_pend[k]),
            .pend     (pend[k]),
            .result   (result[k])
        );
    end

    // PEs finish in index order, so the lowest pending one cannot change
    // while it waits for out_ready.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_dist  = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (pend[k]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(k);
                sel_dist  = result[k];
            end
        end
        clr_pend = (sel_valid && bus.out_ready) ? (NUM_PE'(1) << sel_idx) : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (beat_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LAST)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pend == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.r_ready   = (state_q == RUN);
    assign bus.out_valid = sel_valid;
    assign bus.out_idx   = sel_idx;
    assign bus.out_dist  = sel_dist;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sad_pe_array.sv
// Directed bench: two arrays (ACC_W 8 and 16, NUM_PE=4, BLK=2) fed the same
// beats, each drained result checked against a hand-computed queue.
module tb_sad_pe_array;
    import sad_pkg::*;

    localparam int NP  = 4;
    localparam int PW  = 8;
    localparam int BLK = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    logic          r_valid   = 1'b0;
    logic          out_ready = 1'b1;
    logic [PW-1:0] r_pix     = '0;
    logic [PW-1:0] s1_pix    = '0;
    logic [PW-1:0] s2_pix    = '0;
    logic [NP-1:0] s_sel     = '0;

    logic   busy8, done8, busy16, done16;
    state_e st8, st16;

    sad_pe_array_if #(.NUM_PE(NP), .PIX_W(PW), .ACC_W(8))  bus8 ();
    sad_pe_array_if #(.NUM_PE(NP), .PIX_W(PW), .ACC_W(16)) bus16 ();

    assign bus8.r_valid   = r_valid;
    assign bus8.r_pix     = r_pix;
    assign bus8.s1_pix    = s1_pix;
    assign bus8.s2_pix    = s2_pix;
    assign bus8.s_sel     = s_sel;
    assign bus8.out_ready = out_ready;
    assign bus16.r_valid   = r_valid;
    assign bus16.r_pix     = r_pix;
    assign bus16.s1_pix    = s1_pix;
    assign bus16.s2_pix    = s2_pix;
    assign bus16.s_sel     = s_sel;
    assign bus16.out_ready = out_ready;

    sad_pe_array #(.NUM_PE(NP), .PIX_W(PW), .ACC_W(8), .BLK(BLK)) u_dut8 (
        .clock(clock), .reset(reset), .start(start), .bus(bus8),
        .busy(busy8), .done(done8), .dbg_state(st8)
    );

    sad_pe_array #(.NUM_PE(NP), .PIX_W(PW), .ACC_W(16), .BLK(BLK)) u_dut16 (
        .clock(clock), .reset(reset), .start(start), .bus(bus16),
        .busy(busy16), .done(done16), .dbg_state(st16)
    );

    // Scoreboard: {idx[23:16], dist[15:0]} in expected drain order.
    logic [23:0] exp8_q[$];
    logic [23:0] exp16_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int beat_n  = 0;
    int done8_n = 0;
    int done16_n = 0;
    int burst_chk = 0;
    int r_base, r_step, s1_base, s1_step, s2_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_data();
        r_pix  = PW'(r_base + r_step * beat_n);
        s1_pix = PW'(s1_base + s1_step * beat_n);
        s2_pix = PW'(s2_base);
    endtask

    // Outputs sampled mid-cycle; inputs only change just after posedge.
    always @(negedge clock) begin
        if (!reset) begin
            if (r_valid && bus8.r_ready) beat_n++;
            if (bus8.out_valid) begin
                if (exp8_q.size() == 0) check("out8_unexpected", 32'd1, 32'd0);
                else begin
                    check("out8_idx", 32'(bus8.out_idx), 32'(exp8_q[0][23:16]));
                    check("out8_dist", 32'(bus8.out_dist), 32'(exp8_q[0][15:0]));
                    if (out_ready) void'(exp8_q.pop_front());
                end
            end
            if (bus16.out_valid) begin
                if (exp16_q.size() == 0) check("out16_unexpected", 32'd1, 32'd0);
                else begin
                    check("out16_idx", 32'(bus16.out_idx), 32'(exp16_q[0][23:16]));
                    check("out16_dist", 32'(bus16.out_dist), 32'(exp16_q[0][15:0]));
                    if (out_ready) void'(exp16_q.pop_front());
                end
            end
            if (done8) begin
                done8_n++;
                check("done8_busy_low", 32'(busy8), 32'd0);
                check("done8_q_empty", exp8_q.size(), 32'd0);
            end
            if (done16) begin
                done16_n++;
                check("done16_busy_low", 32'(busy16), 32'd0);
            end
            if (burst_chk > 0) begin
                check("burst_no_bubble", 32'(bus8.out_valid), 32'd1);
                burst_chk--;
            end
        end
    end

    task automatic run_pass(input int toggle, input int hold, input int restart_at,
                            input logic [63:0] e8, input logic [63:0] e16);
        int cyc;
        int hold_n;
        for (int k = 0; k < NP; k++) begin
            exp8_q.push_back({8'(k), e8[k*16 +: 16]});
            exp16_q.push_back({8'(k), e16[k*16 +: 16]});
        end
        beat_n   = 0;
        done8_n  = 0;
        done16_n = 0;
        hold_n   = 0;
        out_ready = (hold == 0);
        set_data();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("pass_busy", 32'(busy8), 32'd1);
        cyc = 0;
        while (cyc < 300 && (done8_n == 0 || done16_n == 0)) begin
            r_valid = (toggle == 0) || (cyc % 2 == 0);
            set_data();
            start = (cyc == restart_at);
            if (hold > 0 && !out_ready) begin
                if (bus8.out_valid) hold_n++;
                if (hold_n > hold) begin
                    out_ready = 1'b1;
                    burst_chk = NP;
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        r_valid = 1'b0;
        out_ready = 1'b1;
        check("pass_finished", 32'(done8_n > 0 && done16_n > 0), 32'd1);
        repeat (5) @(posedge clock);
        #1;
        check("done8_once", done8_n, 32'd1);
        check("done16_once", done16_n, 32'd1);
        check("beats_accepted", beat_n, 32'(BLK * BLK + NP - 1));
        check("idle_busy", 32'(busy8), 32'd0);
        check("idle_state", 32'(st8), 32'(IDLE));
        check("exp8_drained", exp8_q.size(), 32'd0);
        check("exp16_drained", exp16_q.size(), 32'd0);
        exp8_q.delete();
        exp16_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_r_ready", 32'(bus8.r_ready), 32'd0);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_out_dist", 32'(bus8.out_dist), 32'd0);
        check("rst_out_idx", 32'(bus8.out_idx), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_state", 32'(st8), 32'(IDLE));
        reset = 1'b0;
        @(posedge clock); #1;

        // |10-7| = 3 per beat, 4 beats -> 12 on every PE.
        r_base = 10; r_step = 0; s1_base = 7; s1_step = 0; s2_base = 0; s_sel = 4'hF;
        run_pass(0, 0, -1, {4{16'd12}}, {4{16'd12}});

        // |3-200| = 197 per beat -> 788, clamped at 255 for 8-bit sums.
        r_base = 3; s1_base = 0; s2_base = 200; s_sel = 4'h0;
        run_pass(0, 0, -1, {4{16'd255}}, {4{16'd788}});

        // Stalled beats every other cycle must not change the sums.
        r_base = 10; s1_base = 7; s2_base = 0; s_sel = 4'hF;
        run_pass(1, 0, -1, {4{16'd12}}, {4{16'd12}});

        // Downstream back-pressure for 20 cycles.
        run_pass(0, 20, -1, {4{16'd12}}, {4{16'd12}});

        // Reset after three accepted beats aborts the pass silently.
        beat_n = 0;
        done8_n = 0;
        set_data();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        r_valid = 1'b1;
        for (int i = 0; i < 50 && beat_n < 3; i++) begin
            @(posedge clock); #1;
        end
        check("mid_cnt", beat_n, 32'd3);
        check("mid_busy", 32'(busy8), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_r_ready", 32'(bus8.r_ready), 32'd0);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_busy16", 32'(busy16), 32'd0);
        check("mid_rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("mid_rst_out_dist", 32'(bus8.out_dist), 32'd0);
        check("mid_rst_out_idx", 32'(bus8.out_idx), 32'd0);
        check("mid_rst_done", 32'(done8), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        r_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_no_done", done8_n, 32'd0);
        check("post_rst_busy", 32'(busy8), 32'd0);
        run_pass(0, 0, -1, {4{16'd12}}, {4{16'd12}});

        // A start while busy is ignored: still one pass, one done.
        run_pass(0, 0, 2, {4{16'd12}}, {4{16'd12}});

        // R ramps 10/beat, s1 ramps 8/beat, s2 fixed 50; PEs 0,2 use s1.
        // PE k sums |10j - S(j+k)|: 12, 140, 52, 140.
        r_base = 0; r_step = 10; s1_base = 0; s1_step = 8; s2_base = 50; s_sel = 4'b0101;
        run_pass(0, 0, -1, {16'd140, 16'd52, 16'd140, 16'd12},
                           {16'd140, 16'd52, 16'd140, 16'd12});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
